bus_grant_sched: RTL

//   Round-robin scheduler that shares one 12-bit packed-array tri bus between NREQ requesters.

---
 rtl/bgs_pkg.sv | 15 +
 rtl/bgs_rr_pick.sv | 37 +++
 rtl/bus_grant_sched.sv | 140 ++++++++++++++
 3 files changed

// File: rtl/bgs_pkg.sv
// Shared types for the bus grant scheduler: the 12-bit bus word, FSM states
// and the width of the optional hold counter.
package bgs_pkg;

  typedef logic [3:0][4:2] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    TURN  = 2'd2
  } bgs_state_t;

  localparam int unsigned HOLD_W = 4;

endpackage

// File: rtl/bgs_rr_pick.sv
// Combinational round-robin picker: the search starts just after ptr and wraps,
// so the last owner has the lowest priority.
module bgs_rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [$clog2(NREQ)-1:0] win,
  output logic                    any
);

  logic [2*NREQ-1:0] w_dbl;
  logic [NREQ-1:0]   w_rot;
  int                w_start;
  int                w_off;

  // Rotate so the search begins at ptr+1, take the lowest set bit, rotate back.
  always_comb begin
    w_start = (int'(ptr) + 1) % NREQ;
    w_dbl   = {req, req};
    w_rot   = w_dbl[NREQ-1:0];
    for (int i = 0; i < NREQ; i++) begin
      w_rot[i] = w_dbl[w_start + i];
    end
    w_off = 0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (w_rot[i] == 1'b1) begin
        w_off = i;
      end else begin
        w_off = w_off;
      end
    end
    any = |w_rot;
    win = ($clog2(NREQ))'((w_start + w_off) % NREQ);
  end

endmodule

// File: rtl/bus_grant_sched.sv
// Round-robin owner scheduler for a shared tri-state word bus, with one idle
// turnaround cycle between owners. Optional macro BGS_TIMEOUT_EN adds a hold limit.
module bus_grant_sched
  import bgs_pkg::*;
#(
  parameter int NREQ     = 4,
  parameter int MAX_HOLD = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ-1:0]         last,
  input  word_t [NREQ-1:0]        wdata,
  output logic [NREQ-1:0]         gnt,
  output tri word_t               bus,
  output logic                    bus_vld,
  output logic [$clog2(NREQ)-1:0] owner,
  output logic                    revoked
);

  localparam int IW = $clog2(NREQ);

  if (NREQ < 2 || NREQ > 8 || MAX_HOLD < 1 || MAX_HOLD > (1 << HOLD_W)) begin : g_param_check
    $error("bus_grant_sched: NREQ or MAX_HOLD out of range");
  end

  bgs_state_t      r_state;
  bgs_state_t      w_state_nxt;
  logic [NREQ-1:0] r_gnt;
  logic [NREQ-1:0] w_gnt_nxt;
  logic [IW-1:0]   r_owner;
  logic [IW-1:0]   w_owner_nxt;
  logic            r_bus_vld;
  logic            w_vld_nxt;
  logic [IW-1:0]   w_win;
  logic            w_any;
  logic            w_release;
  logic            w_timeout;
  word_t           w_owner_word;

  bgs_rr_pick #(.NREQ(NREQ)) u_pick (
    .req (req),
    .ptr (r_owner),
    .win (w_win),
    .any (w_any)
  );

  assign w_release = last[r_owner] | ~req[r_owner];

`ifdef BGS_TIMEOUT_EN
  logic [HOLD_W-1:0] r_hold;
  logic              r_revoked;

  assign w_timeout = (r_state == GRANT) && (r_hold == HOLD_W'(MAX_HOLD - 1));

  // Hold counter is zero outside GRANT, so it reads 0 on the first GRANT cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hold    <= '0;
      r_revoked <= 1'b0;
    end else begin
      r_revoked <= w_timeout & ~w_release;
      if (r_state == GRANT) begin
        r_hold <= r_hold + HOLD_W'(1);
      end else begin
        r_hold <= '0;
      end
    end
  end

  assign revoked = r_revoked;
`else
  assign w_timeout = 1'b0;
  assign revoked   = 1'b0;
`endif

  // Next-state and registered-output decode; arbitration happens only in IDLE.
  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = r_gnt;
    w_owner_nxt = r_owner;
    w_vld_nxt   = r_bus_vld;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = GRANT;
          w_gnt_nxt   = {{(NREQ-1){1'b0}}, 1'b1} << w_win;
          w_owner_nxt = w_win;
          w_vld_nxt   = 1'b1;
        end else begin
          w_state_nxt = IDLE;
          w_gnt_nxt   = '0;
          w_vld_nxt   = 1'b0;
        end
      end
      GRANT: begin
        if (w_release || w_timeout) begin
          w_state_nxt = TURN;
          w_gnt_nxt   = '0;
          w_vld_nxt   = 1'b0;
        end else begin
          w_state_nxt = GRANT;
        end
      end
      TURN: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_vld_nxt   = 1'b0;
      end
      default: begin
        w_state_nxt = IDLE;
        w_gnt_nxt   = '0;
        w_vld_nxt   = 1'b0;
      end
    endcase
  end

  // State and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_gnt     <= '0;
      r_owner   <= IW'(NREQ - 1);
      r_bus_vld <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_gnt     <= w_gnt_nxt;
      r_owner   <= w_owner_nxt;
      r_bus_vld <= w_vld_nxt;
    end
  end

  assign gnt          = r_gnt;
  assign owner        = r_owner;
  assign bus_vld      = r_bus_vld;
  assign w_owner_word = wdata[r_owner];
  // Release follows the async-reset valid flag, so reset floats the bus at once.
  assign bus          = r_bus_vld ? w_owner_word : {$bits(word_t){1'bz}};

endmodule
